// File: rtl/color_histogram_features_if.sv
// Read-only BRAM port bundle between the histogram engine and the two pixel
// memories it scans (colour-bin BRAM and cluster-ID BRAM).
//   master : histogram engine (drives addresses, receives read data)
//   slave  : BRAM side (receives addresses, returns read data)
// Signals:
//   CIE_AB_COLOR_PORTB_addr  16  pixel address, colour-bin BRAM
//   CIE_AB_COLOR_PORTB_din    8  {a_bin[3:0], b_bin[3:0]}
//   Cluster_ID_PORTB_addr    16  pixel address, cluster BRAM
//   Cluster_ID_PORTB_din      1  1 = foreground cluster
interface color_histogram_features_if;
  logic [15:0] CIE_AB_COLOR_PORTB_addr;
  logic [7:0]  CIE_AB_COLOR_PORTB_din;
  logic [15:0] Cluster_ID_PORTB_addr;
  logic        Cluster_ID_PORTB_din;

  modport master (
    output CIE_AB_COLOR_PORTB_addr,
    output Cluster_ID_PORTB_addr,
    input  CIE_AB_COLOR_PORTB_din,
    input  Cluster_ID_PORTB_din
  );

  modport slave (
    input  CIE_AB_COLOR_PORTB_addr,
    input  Cluster_ID_PORTB_addr,
    output CIE_AB_COLOR_PORTB_din,
    output Cluster_ID_PORTB_din
  );
endinterface

// File: rtl/color_histogram_features.sv
// Colour histogram feature extractor. After the clustering stage finishes,
// scans every pixel of the cluster-ID and colour-bin BRAMs and, for each
// foreground pixel, counts its a-bin and b-bin into 32 saturating counters.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start_hist      level input; a run starts on its rising edge
//   done_hist       high when the histogram is complete, until start_hist drops
//   busy            high from CLEAR through DRAIN
//   bram            BRAM read port bundle (master side)
//   feat_rd_addr    0-15 a-bin counters, 16-31 b-bin counters
//   feat_rd_data    registered counter value, 1-cycle read latency
//   fg_count        number of foreground pixels counted
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a start_hist rising edge
// S_CLEAR | zero one counter per cycle (32 cycles), fg_count on first
// S_READ  | issue addresses 1..TOTAL_PIXELS, one per cycle
// S_DRAIN | let the last RD_LATENCY reads land in the counters
// S_DONE  | done_hist high until start_hist is released
module color_histogram_features #(
  parameter int TOTAL_PIXELS = 50176,
  parameter int RD_LATENCY   = 2,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_hist,
  output logic                          done_hist,
  output logic                          busy,
  color_histogram_features_if.master    bram,
  input  logic [4:0]                    feat_rd_addr,
  output logic [CNT_W-1:0]              feat_rd_data,
  output logic [CNT_W-1:0]              fg_count
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int                DW        = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [15:0]       LAST_ADDR = 16'(TOTAL_PIXELS);

  state_t                 state;
  logic                   start_d;
  logic                   start_pulse;
  logic [4:0]             clr_idx;
  logic [DW-1:0]          drain_cnt;
  logic [15:0]            addr;
  logic [RD_LATENCY-1:0]  vpipe;
  logic [CNT_W-1:0]       cnt [32];
  logic                   acc;
  logic [4:0]             a_idx;
  logic [4:0]             b_idx;

  assign bram.CIE_AB_COLOR_PORTB_addr = addr;
  assign bram.Cluster_ID_PORTB_addr   = addr;

  // a-bins live at 0-15 and b-bins at 16-31, so the two updates never collide.
  assign acc   = vpipe[RD_LATENCY-1] & bram.Cluster_ID_PORTB_din;
  assign a_idx = {1'b0, bram.CIE_AB_COLOR_PORTB_din[7:4]};
  assign b_idx = {1'b1, bram.CIE_AB_COLOR_PORTB_din[3:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      // Resetting the edge detector high means a start_hist level that is
      // still asserted after reset cannot be mistaken for a fresh edge.
      start_d     <= 1'b1;
      start_pulse <= 1'b0;
      done_hist   <= 1'b0;
      busy        <= 1'b0;
      addr        <= '0;
      clr_idx     <= '0;
      drain_cnt   <= '0;
      vpipe       <= '0;
      fg_count    <= '0;
    end else begin
      start_d     <= start_hist;
      start_pulse <= start_hist & ~start_d;
      vpipe       <= (vpipe << 1) | RD_LATENCY'(state == S_READ);

      if (state == S_CLEAR && clr_idx == 5'd0)
        fg_count <= '0;
      else if (acc && fg_count != CNT_MAX)
        fg_count <= fg_count + 1'b1;

      case (state)
        S_IDLE: begin
          done_hist <= 1'b0;
          if (start_pulse) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_idx == 5'd31) begin
            state <= S_READ;
            addr  <= 16'd1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        S_READ: begin
          if (addr == LAST_ADDR) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(RD_LATENCY - 1);
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done_hist <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (!start_hist) begin
            state     <= S_IDLE;
            done_hist <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else if (state == S_CLEAR) begin
      cnt[clr_idx] <= '0;
    end else if (acc) begin
      if (cnt[a_idx] != CNT_MAX) cnt[a_idx] <= cnt[a_idx] + 1'b1;
      if (cnt[b_idx] != CNT_MAX) cnt[b_idx] <= cnt[b_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) feat_rd_data <= '0;
    else       feat_rd_data <= cnt[feat_rd_addr];
  end

endmodule

// File: tb/tb_color_histogram_features.sv
module tb_color_histogram_features;
  localparam int TP      = 8;
  localparam int LAT     = 2;
  localparam int CW      = 16;
  localparam int CLR     = 32;
  localparam int T_ADDR0 = 1 + CLR;              // edge at which addr becomes 1
  localparam int T_DONE  = 1 + CLR + TP + LAT;   // first edge with done_hist high

  logic          clk = 1'b0;
  logic          reset;
  logic          start_hist;
  logic          done_hist;
  logic          busy;
  logic [4:0]    feat_rd_addr;
  logic [CW-1:0] feat_rd_data;
  logic [CW-1:0] fg_count;

  color_histogram_features_if bram ();

  color_histogram_features #(
    .TOTAL_PIXELS(TP),
    .RD_LATENCY  (LAT),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_hist  (start_hist),
    .done_hist   (done_hist),
    .busy        (busy),
    .bram        (bram),
    .feat_rd_addr(feat_rd_addr),
    .feat_rd_data(feat_rd_data),
    .fg_count    (fg_count)
  );

  always #5 clk = ~clk;

  // Pixel memory: address a (1..TP) holds pixel a-1.
  logic [7:0] pix_col [TP];
  logic       pix_cl  [TP];
  logic [7:0] col_r;
  logic       cl_r;

  function automatic logic [7:0] mem_col(input logic [15:0] a);
    if (a >= 16'd1 && a <= 16'(TP)) return pix_col[int'(a) - 1];
    return 8'h00;
  endfunction

  function automatic logic mem_cl(input logic [15:0] a);
    if (a >= 16'd1 && a <= 16'(TP)) return pix_cl[int'(a) - 1];
    return 1'b0;
  endfunction

  // Two-cycle BRAM: address register then output register.
  always @(posedge clk) begin
    col_r                       <= mem_col(bram.CIE_AB_COLOR_PORTB_addr);
    cl_r                        <= mem_cl(bram.Cluster_ID_PORTB_addr);
    bram.CIE_AB_COLOR_PORTB_din <= col_r;
    bram.Cluster_ID_PORTB_din   <= cl_r;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model -----------------------------------------------------
  int cyc  = 0;
  int base = 0;
  bit track = 0;
  int prev_addr = 0;
  int first_done = -1;
  int first_busy = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int hist_model(input int bin);
    int c = 0;
    for (int k = 0; k < TP; k++) begin
      if (pix_cl[k]) begin
        if (bin < 16 && int'(pix_col[k][7:4]) == bin) c++;
        if (bin >= 16 && int'(pix_col[k][3:0]) == bin - 16) c++;
      end
    end
    return c;
  endfunction

  function automatic int exp_addr(input int n);
    if (n < T_ADDR0) return prev_addr;
    if (n - T_ADDR0 + 1 >= TP) return TP;
    return n - T_ADDR0 + 1;
  endfunction

  // Pixel k is addressed in the cycle ending at edge T_ADDR0+1+k and its
  // data arrives LAT cycles later.
  function automatic int exp_fg(input int n);
    int c = 0;
    for (int k = 0; k < TP; k++)
      if (pix_cl[k] && (T_ADDR0 + 1 + k + LAT <= n)) c++;
    return c;
  endfunction

  // Per-cycle compare; rel is the number of the edge just passed, with edge 0
  // being the first edge at which start_hist is sampled high.
  always @(negedge clk) begin
    int rel;
    rel = cyc - base;
    if (track && rel >= 0) begin
      if (rel == 0) begin
        first_done = -1;
        first_busy = -1;
      end
      if (done_hist === 1'b1 && first_done < 0) first_done = rel;
      if (busy === 1'b1 && first_busy < 0) first_busy = rel;
      check("busy", 32'(busy), 32'(rel >= 1 && rel < T_DONE));
      check("done_hist", 32'(done_hist), 32'(rel >= T_DONE));
      check("color_addr", 32'(bram.CIE_AB_COLOR_PORTB_addr), 32'(exp_addr(rel)));
      check("cluster_addr", 32'(bram.Cluster_ID_PORTB_addr), 32'(exp_addr(rel)));
      if (rel >= 2) check("fg_count", 32'(fg_count), 32'(exp_fg(rel)));
    end
  end

  // Stimulus ------------------------------------------------------------
  task automatic do_run(input int hold);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start_hist = 1'b1;
    base  = cyc + 1;
    track = 1'b1;
    repeat (T_DONE + hold) @(posedge clk);
    @(negedge clk);
    track      = 1'b0;
    start_hist = 1'b0;
    prev_addr  = TP;
    check("done_edge", 32'(first_done), 32'd43);
    check("busy_edge", 32'(first_busy), 32'd1);
  endtask

  task automatic read_feat(input int a, output logic [CW-1:0] v);
    @(negedge clk);
    feat_rd_addr = 5'(a);
    @(negedge clk);
    v = feat_rd_data;
  endtask

  task automatic read_all();
    logic [CW-1:0] v;
    for (int i = 0; i < 32; i++) begin
      read_feat(i, v);
      check($sformatf("feat[%0d]", i), 32'(v), 32'(hist_model(i)));
    end
  endtask

  task automatic fill_const(input logic [7:0] c);
    for (int k = 0; k < TP; k++) begin
      pix_col[k] = c;
      pix_cl[k]  = 1'b1;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < TP; k++) begin
      pix_col[k] = 8'($urandom_range(0, 255));
      pix_cl[k]  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [CW-1:0] v;
    reset        = 1'b1;
    start_hist   = 1'b0;
    feat_rd_addr = '0;
    fill_const(8'h00);
    #1;
    check("rst_done", 32'(done_hist), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(bram.CIE_AB_COLOR_PORTB_addr), 32'd0);
    check("rst_fg", 32'(fg_count), 32'd0);
    check("rst_feat", 32'(feat_rd_data), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // All foreground, colour 0x84.
    fill_const(8'h84);
    do_run(5);
    read_all();
    read_feat(8, v);  check("t1_a8", 32'(v), 32'd8);
    read_feat(20, v); check("t1_b4", 32'(v), 32'd8);
    read_feat(0, v);  check("t1_a0", 32'(v), 32'd0);
    check("t1_fg", 32'(fg_count), 32'd8);

    // Rerun with 0x11 after dropping start: old bins must be cleared.
    fill_const(8'h11);
    do_run(5);
    read_all();
    read_feat(1, v);  check("t4_a1", 32'(v), 32'd8);
    read_feat(17, v); check("t4_b1", 32'(v), 32'd8);
    read_feat(8, v);  check("t4_a8", 32'(v), 32'd0);
    read_feat(20, v); check("t4_b4", 32'(v), 32'd0);

    // Alternating foreground/background.
    for (int k = 0; k < TP; k++) begin
      pix_cl[k]  = (k % 2 == 0);
      pix_col[k] = (k % 2 == 0) ? 8'h21 : 8'hFF;
    end
    do_run(5);
    read_all();
    read_feat(2, v);  check("t2_a2", 32'(v), 32'd4);
    read_feat(17, v); check("t2_b1", 32'(v), 32'd4);
    read_feat(15, v); check("t2_a15", 32'(v), 32'd0);
    read_feat(31, v); check("t2_b15", 32'(v), 32'd0);
    check("t2_fg", 32'(fg_count), 32'd4);

    // Random frames, one of them with start held 200 cycles past DONE.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      do_run(r == 1 ? 200 : 5);
      read_all();
    end

    // Reset in the middle of READ, when addr is 4.
    for (int k = 0; k < TP; k++) begin
      pix_col[k] = 8'($urandom_range(0, 255));
      pix_cl[k]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    start_hist = 1'b1;
    base  = cyc + 1;
    track = 1'b1;
    repeat (T_ADDR0 + 4) @(posedge clk);
    #2;
    track = 1'b0;
    check("t5_pre_addr", 32'(bram.CIE_AB_COLOR_PORTB_addr), 32'd4);
    check("t5_pre_fg", 32'(fg_count), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_done", 32'(done_hist), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_fg", 32'(fg_count), 32'd0);
    check("t5_addr", 32'(bram.CIE_AB_COLOR_PORTB_addr), 32'd0);
    check("t5_feat", 32'(feat_rd_data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_idle_busy", 32'(busy), 32'd0);
      check("t5_idle_addr", 32'(bram.Cluster_ID_PORTB_addr), 32'd0);
    end
    for (int i = 0; i < 32; i++) begin
      read_feat(i, v);
      check($sformatf("t5_cleared[%0d]", i), 32'(v), 32'd0);
    end
    start_hist = 1'b0;
    prev_addr  = 0;

    // Recovery after the aborted run.
    fill_random();
    do_run(5);
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
